// File: rtl/vga_timing_receiver_if.sv
// Receive-side VGA link: raw sync/colour in, rebuilt raster, lock status and measurements out.
interface vga_timing_receiver_if;
  logic       pix_en;
  logic       vga_sync_h;
  logic       vga_sync_v;
  logic [5:0] vga_rgb;
  logic [9:0] rx_x;
  logic [9:0] rx_y;
  logic       rx_de;
  logic [5:0] rx_rgb;
  logic       locked;
  logic       timing_err;
  logic [9:0] meas_h_total;
  logic [9:0] meas_v_total;

  modport master (
    output pix_en, vga_sync_h, vga_sync_v, vga_rgb,
    input  rx_x, rx_y, rx_de, rx_rgb, locked, timing_err, meas_h_total, meas_v_total
  );

  modport slave (
    input  pix_en, vga_sync_h, vga_sync_v, vga_rgb,
    output rx_x, rx_y, rx_de, rx_rgb, locked, timing_err, meas_h_total, meas_v_total
  );
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA sink: rebuilds the raster from sync edges, measures line/frame length and tracks lock.
// Pixel sampled at strobe n is on rx_* at strobe n+2; no backpressure, every strobe is consumed.
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input logic             clk,
  input logic             rst,
  vga_timing_receiver_if.slave link
);

  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [9:0]  H_BEG  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_END  = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  state_t     state;
  logic [3:0] good;

  logic       s1_h, s1_v, s1_h_prev, s1_v_prev;
  logic [5:0] s1_rgb, s2_rgb;
  logic [9:0] h_cnt, v_cnt;
  logic       v_pend, h_seen, v_seen, h_stuck;

  logic [9:0] out_x, out_y, out_meas_h, out_meas_v;
  logic [5:0] out_rgb;
  logic       out_de, out_locked, out_err;

  logic        h_fall, v_fall, frame_evt;
  logic [10:0] h_len, v_len;
  logic        h_bad, v_bad, stuck_hit, mismatch, active;

  always_comb begin
    h_fall    = !s1_h && s1_h_prev;
    v_fall    = !s1_v && s1_v_prev;
    frame_evt = h_fall && (v_pend || v_fall);
    h_len     = {1'b0, h_cnt} + 11'd1;
    v_len     = {1'b0, v_cnt} + 11'd1;
    // A line that ends a stuck-sync period was already reported once.
    h_bad     = h_fall && h_seen && !h_stuck && (h_len != H_TOT);
    stuck_hit = !h_fall && !h_stuck && (h_cnt == CNT_MAX);
    // The first frame after reset starts at an arbitrary point, so it is not judged.
    v_bad     = frame_evt && v_seen && (v_len != V_TOT);
    mismatch  = h_bad || stuck_hit || v_bad;
    active    = (h_cnt >= H_BEG) && (h_cnt < H_END) && (v_cnt >= V_BEG) && (v_cnt < V_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      good       <= '0;
      s1_h       <= 1'b1;
      s1_v       <= 1'b1;
      s1_h_prev  <= 1'b1;
      s1_v_prev  <= 1'b1;
      s1_rgb     <= '0;
      s2_rgb     <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      v_pend     <= 1'b0;
      h_seen     <= 1'b0;
      v_seen     <= 1'b0;
      h_stuck    <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_rgb    <= '0;
      out_de     <= 1'b0;
      out_locked <= 1'b0;
      out_err    <= 1'b0;
      out_meas_h <= '0;
      out_meas_v <= '0;
    end else begin
      out_err <= 1'b0;
      if (link.pix_en) begin
        s1_h      <= link.vga_sync_h;
        s1_v      <= link.vga_sync_v;
        s1_rgb    <= link.vga_rgb;
        s1_h_prev <= s1_h;
        s1_v_prev <= s1_v;
        s2_rgb    <= s1_rgb;

        if (h_fall) begin
          h_cnt      <= '0;
          h_seen     <= 1'b1;
          h_stuck    <= 1'b0;
          out_meas_h <= h_len[9:0];
        end else begin
          if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 10'd1;
          if (stuck_hit) h_stuck <= 1'b1;
        end

        if (frame_evt) begin
          v_cnt      <= '0;
          v_pend     <= 1'b0;
          v_seen     <= 1'b1;
          out_meas_v <= v_len[9:0];
        end else begin
          if (h_fall && v_cnt != CNT_MAX) v_cnt <= v_cnt + 10'd1;
          if (v_fall) v_pend <= 1'b1;
        end

        out_err <= mismatch;

        case (state)
          UNLOCKED: begin
            if (frame_evt && !mismatch) begin
              state <= CHECK;
              good  <= '0;
            end
          end
          CHECK: begin
            if (mismatch) begin
              state <= UNLOCKED;
            end else if (frame_evt) begin
              good <= good + 4'd1;
              if (good + 4'd1 == LOCK_N) begin
                state      <= LOCKED;
                out_locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (mismatch) begin
              state      <= UNLOCKED;
              out_locked <= 1'b0;
            end
          end
          default: begin
            state      <= UNLOCKED;
            out_locked <= 1'b0;
          end
        endcase

        // Coordinates and colour hold their last values outside the active window.
        out_de <= active && out_locked;
        if (active && out_locked) begin
          out_x   <= h_cnt - H_BEG;
          out_y   <= v_cnt - V_BEG;
          out_rgb <= s2_rgb;
        end
      end
    end
  end

  assign link.rx_x         = out_x;
  assign link.rx_y         = out_y;
  assign link.rx_de        = out_de;
  assign link.rx_rgb       = out_rgb;
  assign link.locked       = out_locked;
  assign link.timing_err   = out_err;
  assign link.meas_h_total = out_meas_h;
  assign link.meas_v_total = out_meas_v;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a reduced raster so several frames fit in a short run.
module tb_vga_timing_receiver;

  localparam int HT = 40, HS = 4, HB = 6, HA = 24;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  vga_timing_receiver_if bus();

  vga_timing_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(bus)
  );

  typedef struct {
    int         h;
    int         v;
    logic [5:0] rgb;
    logic       exp_de;
    bit         chk;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic [5:0] exp_rgb;
  } vec_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] rgb;
  } pix_t;

  typedef struct {
    int idx;
    int due;
  } pend_t;

  vec_t  tbl[7];
  pix_t  sb_q[$];
  pend_t pend_q[$];

  int checks = 0, failures = 0;
  int gh = 0, gv = 0, n_strobe = 0;
  bit short_line = 0, sb_on = 0;
  logic smp_err, smp_locked, smp2_err;
  int err_cnt = 0, width_viol = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.timing_err === 1'b1) begin
      err_cnt++;
      if (err_prev === 1'b1) width_viol++;
    end
    err_prev = bus.timing_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_active(input int h, input int v);
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  // One pixel strobe followed by one idle clock; hold=1 keeps both syncs high without advancing the raster.
  task automatic drive(input logic [5:0] ovr, input bit use_ovr, input bit hold);
    logic [5:0] c;
    pix_t  e;
    pend_t p;
    c = is_active(gh, gv) ? 6'((gh * 5 + gv * 11 + 1) % 64) : 6'h00;
    if (use_ovr) c = ovr;
    if (hold) c = 6'h00;
    bus.vga_sync_h = hold ? 1'b1 : (gh >= HS);
    bus.vga_sync_v = hold ? 1'b1 : (gv >= VS);
    bus.vga_rgb    = c;
    bus.pix_en     = 1'b1;
    if (sb_on && !hold && is_active(gh, gv))
      sb_q.push_back('{10'(gh - HS - HB), 10'(gv - VS - VB), c});
    @(posedge clk); #1;
    n_strobe++;
    smp_err    = bus.timing_err;
    smp_locked = bus.locked;
    if (bus.rx_de === 1'b1 && (sb_on || sb_q.size() > 0)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_de", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_x", bus.rx_x, e.x);
        check("sb_y", bus.rx_y, e.y);
        check("sb_rgb", bus.rx_rgb, e.rgb);
      end
    end
    if (pend_q.size() > 0 && pend_q[0].due == n_strobe) begin
      p = pend_q.pop_front();
      check($sformatf("vec%0d_de", p.idx), bus.rx_de, tbl[p.idx].exp_de);
      if (tbl[p.idx].chk) begin
        check($sformatf("vec%0d_x", p.idx), bus.rx_x, tbl[p.idx].exp_x);
        check($sformatf("vec%0d_y", p.idx), bus.rx_y, tbl[p.idx].exp_y);
        check($sformatf("vec%0d_rgb", p.idx), bus.rx_rgb, tbl[p.idx].exp_rgb);
      end
    end
    bus.pix_en = 1'b0;
    @(posedge clk); #1;
    smp2_err = bus.timing_err;
    if (!hold) begin
      gh++;
      if (gh == (short_line ? HT - 1 : HT)) begin
        gh = 0;
        short_line = 0;
        gv = (gv + 1) % VT;
      end
    end
  endtask

  task automatic step();
    drive(6'h00, 1'b0, 1'b0);
  endtask

  task automatic goto(input int h, input int v);
    while (!(gh == h && gv == v)) step();
  endtask

  // Lock must rise exactly at the processing of the third frame start.
  task automatic lock_seq(input string tag);
    for (int k = 1; k <= 3; k++) begin
      goto(0, 0);
      step();
      check($sformatf("%s_pre_evt%0d_locked", tag, k), smp_locked, 1'b0);
      step();
      check($sformatf("%s_evt%0d_locked", tag, k), smp_locked, (k == 3) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    int e0;
    tbl[0] = '{10, 4,  6'h3F, 1'b0, 1'b0, 10'd0,  10'd0,  6'h00};
    tbl[1] = '{9,  5,  6'h3F, 1'b0, 1'b0, 10'd0,  10'd0,  6'h00};
    tbl[2] = '{10, 5,  6'h2D, 1'b1, 1'b1, 10'd0,  10'd0,  6'h2D};
    tbl[3] = '{20, 8,  6'h3F, 1'b1, 1'b1, 10'd10, 10'd3,  6'h3F};
    tbl[4] = '{33, 16, 6'h12, 1'b1, 1'b1, 10'd23, 10'd11, 6'h12};
    tbl[5] = '{34, 16, 6'h00, 1'b0, 1'b1, 10'd23, 10'd11, 6'h12};
    tbl[6] = '{10, 17, 6'h3F, 1'b0, 1'b0, 10'd0,  10'd0,  6'h00};

    bus.pix_en = 1'b0;
    bus.vga_sync_h = 1'b1;
    bus.vga_sync_v = 1'b1;
    bus.vga_rgb = 6'h00;

    // Reset with idle syncs.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rx_x", bus.rx_x, 10'd0);
    check("rst_rx_y", bus.rx_y, 10'd0);
    check("rst_rx_de", bus.rx_de, 1'b0);
    check("rst_rx_rgb", bus.rx_rgb, 6'd0);
    check("rst_locked", bus.locked, 1'b0);
    check("rst_timing_err", bus.timing_err, 1'b0);
    check("rst_meas_h", bus.meas_h_total, 10'd0);
    check("rst_meas_v", bus.meas_v_total, 10'd0);

    // Nominal stream locks on the third frame start with no errors.
    lock_seq("nominal");
    check("nominal_no_err", err_cnt, 0);
    check("nominal_meas_h", bus.meas_h_total, 10'(HT));
    check("nominal_meas_v", bus.meas_v_total, 10'(VT));

    // Pixel probes plus full-frame scoreboard while locked.
    sb_on = 1;
    for (int i = 0; i < 7; i++) begin
      goto(tbl[i].h, tbl[i].v);
      drive(tbl[i].rgb, 1'b1, 1'b0);
      pend_q.push_back('{i, n_strobe + 2});
    end
    repeat (4) step();
    sb_on = 0;
    check("sb_drained", sb_q.size(), 0);
    check("vec_drained", pend_q.size(), 0);

    // Short line drops lock on the same edge as the error pulse.
    goto(0, 3);
    short_line = 1;
    goto(0, 4);
    e0 = err_cnt;
    step();
    check("short_pre_locked", smp_locked, 1'b1);
    check("short_pre_err", smp_err, 1'b0);
    step();
    check("short_err", smp_err, 1'b1);
    check("short_locked", smp_locked, 1'b0);
    check("short_meas_h", bus.meas_h_total, 10'(HT - 1));
    check("short_err_cleared", smp2_err, 1'b0);
    lock_seq("short_relock");
    check("short_err_count", err_cnt - e0, 1);

    // Stuck hsync: one error only, then relock.
    goto(0, 8);
    e0 = err_cnt;
    for (int i = 0; i < 1100; i++) drive(6'h00, 1'b0, 1'b1);
    check("stuck_err_once", err_cnt - e0, 1);
    check("stuck_locked", bus.locked, 1'b0);
    lock_seq("stuck_relock");
    check("stuck_err_total", err_cnt - e0, 1);

    // Reset mid-frame while locked.
    goto(15, 8);
    step();
    check("midrst_pre_de", bus.rx_de, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_locked", bus.locked, 1'b0);
    check("midrst_de", bus.rx_de, 1'b0);
    check("midrst_meas_h", bus.meas_h_total, 10'd0);
    e0 = err_cnt;
    lock_seq("midrst_relock");
    check("midrst_no_err", err_cnt - e0, 0);

    check("err_pulse_width", width_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
